// File: rtl/moxie_fetch_buffer.sv
// moxie_fetch_buffer
//   Instruction fetch buffer between instruction memory and the Moxie decode stage.
//   A circular queue of 16-bit parcels is filled by word fetches over a req/ack
//   handshake. The head three parcels are presented to decode, which consumes 1 or
//   3 parcels per cycle. A redirect flushes the queue and restarts fetch at any
//   halfword address.
//
//   Optional feature: define MOXIE_FETCH_BYPASS_EN to let an ack into an empty
//   queue show its parcels on dec_avail/dec_data in the same cycle.
//
// Ports
//   clk, reset           clock; synchronous active-high reset
//   redirect_valid/addr  flush and restart fetch at redirect_addr (bit 0 ignored)
//   mem_req/addr         fetch request, address aligned to MEM_W/8 bytes
//   mem_ack/rdata        completes the outstanding request; big-endian parcels
//   dec_avail            valid parcels at the head, saturating at 3
//   dec_data             head parcels, head in [47:32]; invalid lanes are 0
//   dec_pc               byte address of the head parcel
//   dec_take/take_len    consume 1 or 3 parcels
//   take_err             one-cycle pulse after an illegal take
module moxie_fetch_buffer #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       MEM_W     = 32,
  parameter int unsigned       DEPTH     = 8,
  parameter logic [ADDR_W-1:0] BOOT_ADDR = 32'h0000_1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [MEM_W-1:0]  mem_rdata,
  output logic [1:0]        dec_avail,
  output logic [47:0]       dec_data,
  output logic [ADDR_W-1:0] dec_pc,
  input  logic              dec_take,
  input  logic [1:0]        dec_take_len,
  output logic              take_err
);

  localparam int unsigned       P          = MEM_W / 16;
  localparam int unsigned       PTR_W      = $clog2(DEPTH);
  localparam int unsigned       CNT_W      = PTR_W + 1;
  localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(MEM_W / 8);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(MEM_W / 8 - 1);

  typedef enum logic [1:0] {StIdle, StWait, StWaitDiscard} state_e;

  state_e            state_q, state_d;
  logic [15:0]       q_mem [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] fetch_ptr_q, fetch_ptr_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              take_err_q, take_err_d;

  logic [ADDR_W-1:0] fetch_base, redirect_pc;
  logic [CNT_W-1:0]  skip, n_write, n_take, avail_cnt, space_before, space_after;
  logic              ack_data, take_ok;
  logic [MEM_W-1:0]  shifted;
  logic [15:0]       in_parcel [P];
`ifdef MOXIE_FETCH_BYPASS_EN
  logic [MEM_W+47:0] in_pad;
`endif

  // Incoming word: leading parcels below an unaligned fetch pointer are skipped by
  // shifting them out, so the remaining parcels always start at lane 0.
  always_comb begin
    redirect_pc = redirect_addr & ~ADDR_W'(1);
    fetch_base  = fetch_ptr_q & ALIGN_MASK;
    skip        = CNT_W'((fetch_ptr_q - fetch_base) >> 1);
    ack_data    = (state_q == StWait) && mem_ack && !redirect_valid;
    n_write     = ack_data ? (CNT_W'(P) - skip) : '0;
    shifted     = mem_rdata << {skip, 4'b0000};
    for (int unsigned i = 0; i < P; i++) begin
      in_parcel[i] = shifted[MEM_W-1-16*i -: 16];
    end
`ifdef MOXIE_FETCH_BYPASS_EN
    in_pad = {shifted, 48'h0};
`endif
  end

  // Decode-facing view of the head of the queue.
  always_comb begin
    avail_cnt = count_q;
`ifdef MOXIE_FETCH_BYPASS_EN
    if (count_q == '0 && ack_data) avail_cnt = n_write;
`endif
    dec_avail = (avail_cnt >= CNT_W'(3)) ? 2'd3 : avail_cnt[1:0];
    dec_data  = '0;
    for (int unsigned i = 0; i < 3; i++) begin
`ifdef MOXIE_FETCH_BYPASS_EN
      if (CNT_W'(i) < avail_cnt) begin
        dec_data[47-16*i -: 16] = (count_q == '0) ? in_pad[MEM_W+47-16*i -: 16]
                                                  : q_mem[head_q + PTR_W'(i)];
      end
`else
      if (CNT_W'(i) < avail_cnt) dec_data[47-16*i -: 16] = q_mem[head_q + PTR_W'(i)];
`endif
    end
  end

  always_comb begin
    take_ok = dec_take && (dec_take_len == 2'd1 || dec_take_len == 2'd3) &&
              (dec_take_len <= dec_avail);
    n_take      = (take_ok && !redirect_valid) ? CNT_W'(dec_take_len) : '0;
    take_err_d  = dec_take && !take_ok && !redirect_valid;

    // Issue decisions from IDLE use the count before this cycle's take, so the
    // queue can never be over-committed while a request is in flight.
    space_before = CNT_W'(DEPTH) - count_q;
    count_d      = count_q + n_write - n_take;
    space_after  = CNT_W'(DEPTH) - count_d;
    head_d       = head_q + n_take[PTR_W-1:0];
    tail_d       = tail_q + n_write[PTR_W-1:0];
    pc_d         = pc_q + ADDR_W'({n_take, 1'b0});

    state_d     = state_q;
    fetch_ptr_d = fetch_ptr_q;
    req_addr_d  = req_addr_q;
    unique case (state_q)
      StIdle: begin
        if (!redirect_valid && space_before >= CNT_W'(P)) begin
          state_d    = StWait;
          req_addr_d = fetch_base;
        end
      end
      StWait: begin
        if (redirect_valid) begin
          // Without a same-cycle ack the old request is still owed a response.
          state_d = mem_ack ? StIdle : StWaitDiscard;
        end else if (mem_ack) begin
          fetch_ptr_d = fetch_base + WORD_BYTES;
          req_addr_d  = fetch_base + WORD_BYTES;
          state_d     = (space_after >= CNT_W'(P)) ? StWait : StIdle;
        end
      end
      StWaitDiscard: begin
        if (mem_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (redirect_valid) begin
      count_d     = '0;
      head_d      = tail_q;
      pc_d        = redirect_pc;
      fetch_ptr_d = redirect_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      pc_q        <= BOOT_ADDR;
      fetch_ptr_q <= BOOT_ADDR;
      req_addr_q  <= BOOT_ADDR & ALIGN_MASK;
      take_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      pc_q        <= pc_d;
      fetch_ptr_q <= fetch_ptr_d;
      req_addr_q  <= req_addr_d;
      take_err_q  <= take_err_d;
    end
  end

  // Parcel storage; contents are only ever read through the count-masked lanes.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < P; i++) begin
      if (CNT_W'(i) < n_write) q_mem[tail_q + PTR_W'(i)] <= in_parcel[i];
    end
  end

  assign mem_req  = (state_q != StIdle);
  assign mem_addr = req_addr_q;
  assign dec_pc   = pc_q;
  assign take_err = take_err_q;

endmodule
